// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle for multicycle_controller: instruction fetch
// request/ready and data access request/write/ready.
interface multicycle_controller_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a
// wait-cycle timeout on both memory ports.
// Build option: define ILLEGAL_TRAP_EN to send an illegal (zero or
// non-one-hot) instruction type into a terminal TRAP state; otherwise it
// retires as a NOP.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_CNT_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [8:0]                    insn_type,
    input  logic                          branch_taken,
    multicycle_controller_if.master       mem,
    output logic                          ir_we,
    output logic                          pc_we,
    output logic [1:0]                    pc_sel,
    output logic                          alu_a_sel,
    output logic                          alu_b_sel,
    output logic [1:0]                    wb_sel,
    output logic                          reg_we,
    output logic                          retire,
    output logic                          bus_err,
    output logic [2:0]                    state
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'b000,
        S_DECODE  = 3'b001,
        S_EXECUTE = 3'b010,
        S_MEM     = 3'b011,
        S_WB      = 3'b100,
        S_TRAP    = 3'b101
    } state_t;

    // Bit positions inside the one-hot instruction-type vector
    localparam int unsigned T_R     = 0;
    localparam int unsigned T_LW    = 1;
    localparam int unsigned T_JALR  = 3;
    localparam int unsigned T_S     = 4;
    localparam int unsigned T_SB    = 5;
    localparam int unsigned T_AUIPC = 6;
    localparam int unsigned T_LUI   = 7;
    localparam int unsigned T_UJ    = 8;

    state_t               state_q, state_d;
    logic [8:0]           type_q, type_d;
    logic [TO_CNT_W-1:0]  cnt_q, cnt_d;
    // Set for the single FETCH cycle after a timeout so the request drops
    // for one cycle even though the state stays (or returns to) FETCH.
    logic                 drop_q, drop_d;

    logic                 legal;
    logic                 to_limit;
    logic [TO_CNT_W-1:0]  cnt_inc;

    assign legal    = $onehot(type_q);
    assign to_limit = (MEM_TIMEOUT != 0) && (cnt_q == TO_CNT_W'(MEM_TIMEOUT));
    assign cnt_inc  = (MEM_TIMEOUT == 0) ? '0 : cnt_q + TO_CNT_W'(1);
    assign state    = state_q;

    // State, latched instruction type, timeout counter and drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            type_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic and all control outputs
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        cnt_d        = '0;
        drop_d       = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        wb_sel       = 2'b00;
        reg_we       = 1'b0;
        retire       = 1'b0;
        bus_err      = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (!drop_q) begin
                    mem.imem_req = 1'b1;
                    if (mem.imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (to_limit) begin
                        bus_err = 1'b1;
                        drop_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_DECODE: begin
                type_d  = insn_type;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_a_sel = legal & (type_q[T_AUIPC] | type_q[T_UJ]);
                alu_b_sel = legal & ~(type_q[T_R] | type_q[T_SB]);
                if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
`endif
                end else if (type_q[T_LW] | type_q[T_S]) begin
                    state_d = S_MEM;
                end else if (type_q[T_SB]) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = type_q[T_S];
                if (mem.dmem_ready) begin
                    if (type_q[T_S]) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (to_limit) begin
                    bus_err = 1'b1;
                    drop_d  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                if (type_q[T_JALR])    pc_sel = 2'b10;
                else if (type_q[T_UJ]) pc_sel = 2'b01;
                if (type_q[T_LW])                       wb_sel = 2'b01;
                else if (type_q[T_UJ] | type_q[T_JALR]) wb_sel = 2'b10;
                else if (type_q[T_LUI])                 wb_sel = 2'b11;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver schedules each
// instruction cycle by cycle and pushes the expected retire/bus_err event;
// a monitor pops and compares whenever the controller reports one.
module tb_multicycle_controller;
    localparam int unsigned TO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] insn_type;
    logic       branch_taken;
    logic       ir_we, pc_we, alu_a_sel, alu_b_sel, reg_we, retire, bus_err;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;

    multicycle_controller_if mem_bus ();

    multicycle_controller #(.MEM_TIMEOUT(TO), .TO_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .insn_type(insn_type), .branch_taken(branch_taken),
        .mem(mem_bus), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
        .reg_we(reg_we), .retire(retire), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; bit err; bit reg_we; bit pc_we; int pc_sel; int wb_sel; int st;
        int n_imem; int n_irwe; int n_dmem; int n_dwe; bit alu_a; bit alu_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   dcyc  = 0;
    int   mcyc  = 0;

    function automatic void check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, mcyc);
        end
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [8:0] r9();
        return 9'($urandom);
    endfunction

    task automatic cyc(input logic ir, input logic dr, input logic [8:0] ty, input logic bt);
        @(negedge clk);
        dcyc++;
        mem_bus.imem_ready = ir;
        mem_bus.dmem_ready = dr;
        insn_type          = ty;
        branch_taken       = bt;
    endtask

    // One instruction: iw/dw are wait cycles before ready; above TO means the port never answers
    task automatic run_txn(input logic [8:0] t, input int iw, input int dw, input logic bt);
        exp_t e;
        int   s, ex, m, n;
        bit   legal, is_lw, is_s, mem_op, f_to, m_to;
        e      = '{default: 0};
        s      = dcyc + 1;
        legal  = ($countones(t) == 1);
        is_lw  = legal && t[1];
        is_s   = legal && t[4];
        mem_op = is_lw || is_s;
        f_to   = (iw > int'(TO));
        m_to   = mem_op && (dw > int'(TO)) && !f_to;
        if (f_to) begin
            e.cyc = s + TO; e.err = 1; e.st = 0; e.n_imem = TO + 1;
            n = TO + 2;
        end else begin
            e.n_imem = iw + 1;
            e.n_irwe = 1;
            e.alu_a  = legal && (t[6] || t[8]);
            e.alu_b  = legal && !(t[0] || t[5]);
            ex = s + iw + 2;
            m  = ex + 1;
            if (!legal || t[5]) begin
                e.cyc = ex; e.pc_we = 1; e.pc_sel = (legal && bt) ? 1 : 0; e.st = 2;
                n = iw + 3;
            end else if (m_to) begin
                e.cyc = m + TO; e.err = 1; e.st = 3;
                e.n_dmem = TO + 1; e.n_dwe = is_s ? TO + 1 : 0;
                n = iw + 3 + TO + 2;
            end else if (is_s) begin
                e.cyc = m + dw; e.pc_we = 1; e.st = 3; e.n_dmem = dw + 1; e.n_dwe = dw + 1;
                n = iw + 3 + dw + 1;
            end else if (is_lw) begin
                e.cyc = m + dw + 1; e.pc_we = 1; e.reg_we = 1; e.wb_sel = 1; e.st = 4;
                e.n_dmem = dw + 1;
                n = iw + 3 + dw + 2;
            end else begin
                e.cyc = ex + 1; e.reg_we = 1; e.pc_we = 1; e.st = 4;
                e.pc_sel = t[3] ? 2 : (t[8] ? 1 : 0);
                e.wb_sel = (t[8] || t[3]) ? 2 : (t[7] ? 3 : 0);
                n = iw + 4;
            end
        end
        sb_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            logic ir, dr, b;
            logic [8:0] ty;
            ir = rb(); dr = rb(); ty = r9(); b = rb();
            if (f_to) begin
                ir = 1'b0;
            end else begin
                if (k <= iw) ir = (k == iw);
                if (k == iw + 1) ty = t;
                if (k == iw + 2) b = bt;
                if (mem_op && k >= iw + 3) dr = m_to ? 1'b0 : (k == iw + 3 + dw);
            end
            cyc(ir, dr, ty, b);
        end
    endtask

    task automatic reset_in_mem();
        cyc(1'b1, 1'b0, r9(), rb());
        cyc(1'b0, 1'b0, 9'h002, rb());
        cyc(1'b0, 1'b0, r9(), rb());
        cyc(1'b0, 1'b0, r9(), rb());
        #3;
        check("dmem_req_before_reset", int'(mem_bus.dmem_req), 1);
        rst_n = 1'b0;
        #1;
        check("dmem_req_async_reset", int'(mem_bus.dmem_req), 0);
        check("state_async_reset", int'(state), 0);
        cyc(1'b0, 1'b0, r9(), rb());
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("state_after_release", int'(state), 0);
    endtask

`ifdef ILLEGAL_TRAP_EN
    task automatic trap_seq(input logic [8:0] t);
        cyc(1'b1, 1'b0, r9(), 1'b0);
        cyc(1'b0, 1'b0, t, 1'b0);
        cyc(1'b0, 1'b0, r9(), 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(rb(), rb(), r9(), rb());
            #2;
            check("trap_state", int'(state), 5);
            check("trap_imem_req", int'(mem_bus.imem_req), 0);
            check("trap_pc_we", int'(pc_we), 0);
            check("trap_retire", int'(retire), 0);
        end
        rst_n = 1'b0;
        #1;
        check("trap_state_reset", int'(state), 0);
        cyc(1'b0, 1'b0, r9(), 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
`endif

    // Monitor: accumulate activity between events, compare on retire/bus_err
    initial begin
        int   a_im, a_ir, a_dm, a_dw, stray;
        bit   aa, ab;
        exp_t e;
        a_im = 0; a_ir = 0; a_dm = 0; a_dw = 0; stray = 0; aa = 0; ab = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            #2;
            if (!rst_n) begin
                a_im = 0; a_ir = 0; a_dm = 0; a_dw = 0; stray = 0; aa = 0; ab = 0;
                continue;
            end
            while (sb_q.size() > 0 && sb_q[0].cyc < mcyc) begin
                check("missed_event_cycle", mcyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            a_im += int'(mem_bus.imem_req);
            a_ir += int'(ir_we);
            a_dm += int'(mem_bus.dmem_req);
            a_dw += int'(mem_bus.dmem_we);
            aa |= alu_a_sel;
            ab |= alu_b_sel;
            if (retire || bus_err) begin
                if (sb_q.size() == 0) begin
                    check("pending_expect", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("event_cycle", mcyc, e.cyc);
                    check("bus_err", int'(bus_err), int'(e.err));
                    check("retire", int'(retire), int'(!e.err));
                    check("reg_we", int'(reg_we), int'(e.reg_we));
                    check("pc_we", int'(pc_we), int'(e.pc_we));
                    check("pc_sel", int'(pc_sel), e.pc_sel);
                    check("wb_sel", int'(wb_sel), e.wb_sel);
                    check("state", int'(state), e.st);
                    check("imem_req_cycles", a_im, e.n_imem);
                    check("ir_we_cycles", a_ir, e.n_irwe);
                    check("dmem_req_cycles", a_dm, e.n_dmem);
                    check("dmem_we_cycles", a_dw, e.n_dwe);
                    check("alu_a_sel", int'(aa), int'(e.alu_a));
                    check("alu_b_sel", int'(ab), int'(e.alu_b));
                    check("stray_pc_or_reg_we", stray, 0);
                end
                a_im = 0; a_ir = 0; a_dm = 0; a_dw = 0; stray = 0; aa = 0; ab = 0;
            end else if (pc_we || reg_we) begin
                stray++;
            end
        end
    end

    // Driver
    initial begin
        logic [8:0] t;
        int u, iw, dw;
        rst_n = 1'b0;
        mem_bus.imem_ready = 1'b0;
        mem_bus.dmem_ready = 1'b0;
        insn_type = '0;
        branch_taken = 1'b0;
        cyc(1'b0, 1'b0, 9'h000, 1'b0);
        #2;
        check("rst_state", int'(state), 0);
        check("rst_imem_req", int'(mem_bus.imem_req), 1);
        check("rst_dmem_req", int'(mem_bus.dmem_req), 0);
        check("rst_dmem_we", int'(mem_bus.dmem_we), 0);
        check("rst_ir_we", int'(ir_we), 0);
        check("rst_pc_we", int'(pc_we), 0);
        check("rst_reg_we", int'(reg_we), 0);
        check("rst_retire", int'(retire), 0);
        check("rst_bus_err", int'(bus_err), 0);
        check("rst_selects", int'({pc_sel, wb_sel, alu_a_sel, alu_b_sel}), 0);
        cyc(1'b0, 1'b0, 9'h000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_txn(9'h001, 0, 0, 1'b0);
        run_txn(9'h002, 0, 2, 1'b0);
        run_txn(9'h020, 0, 0, 1'b1);
        run_txn(9'h020, 1, 0, 1'b0);
        run_txn(9'h010, 0, 1, 1'b0);
        run_txn(9'h004, 0, 0, 1'b0);
        run_txn(9'h008, 2, 0, 1'b0);
        run_txn(9'h040, 0, 0, 1'b0);
        run_txn(9'h080, 0, 0, 1'b0);
        run_txn(9'h100, 0, 0, 1'b0);
        run_txn(9'h001, TO + 1, 0, 1'b0);
        run_txn(9'h001, TO, 0, 1'b0);
        run_txn(9'h002, 0, TO, 1'b0);
        run_txn(9'h010, 0, TO + 1, 1'b0);
        run_txn(9'h002, 1, TO + 1, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        run_txn(9'h000, 0, 0, 1'b0);
        run_txn(9'h003, 1, 0, 1'b1);
`endif
        reset_in_mem();
        run_txn(9'h001, 0, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            u = int'($urandom_range(0, 11));
            t = 9'h001 << u[3:0];
            if (u > 8) begin
                t = 9'h001 << $urandom_range(0, 8);
`ifndef ILLEGAL_TRAP_EN
                if (u == 9)  t = 9'h000;
                if (u == 10) t = r9();
`endif
            end
            u  = int'($urandom_range(0, 15));
            iw = (u < 10) ? int'($urandom_range(0, 2)) : (u < 13) ? int'($urandom_range(0, TO)) : (u < 14) ? int'(TO) + 1 : 0;
            u  = int'($urandom_range(0, 15));
            dw = (u < 10) ? int'($urandom_range(0, 2)) : (u < 13) ? int'($urandom_range(0, TO)) : (u < 14) ? int'(TO) + 1 : 0;
            run_txn(t, iw, dw, rb());
        end

`ifdef ILLEGAL_TRAP_EN
        trap_seq(9'h003);
        trap_seq(9'h000);
        run_txn(9'h001, 0, 0, 1'b0);
`endif

        cyc(1'b0, 1'b0, 9'h000, 1'b0);
        #3;
        check("leftover_expects", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
